regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameters SHALL be: DW, 8, data width; AW, 2, register address width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 core_wr_valid / core_wr_addr / core_wr_data  in  1/AW/DW  core write-back request.
REQ-005 core_wr_ready  out  1  core request accepted this cycle when valid and ready both high.
REQ-006 dbg_valid / dbg_we / dbg_addr / dbg_wdata  in  1/1/AW/DW  debug request; dbg_we=1 write, 0 read.
REQ-007 dbg_ready  out  1  debug request accepted this cycle when valid and ready both high.
REQ-008 dbg_rdata / dbg_rvalid  out  DW/1  debug read data and its one-cycle valid strobe.
REQ-009 dbg_halt_req  in  1; dbg_halted  out  1; core_stall  out  1  halt handshake.
REQ-010 rf_reg_write / rf_rd_addr / rf_write_data  out  1/AW/DW  register file port; rf_rd_data  in  DW  combinational read data at rf_rd_addr.

Function
REQ-011 At most one request SHALL be accepted per cycle; accepted requests SHALL enter a single-entry issue register (iss_valid, iss_we, iss_addr, iss_data) at the accepting edge.
REQ-012 rf_reg_write, rf_rd_addr, rf_write_data SHALL be registered: rf_reg_write = 1 for exactly the cycle after a write is accepted; rf_rd_addr/rf_write_data SHALL hold the last issued values while idle.
REQ-013 A debug read accepted at edge E0 SHALL drive rf_rd_addr during the cycle after E0; rf_rd_data SHALL be captured into dbg_rdata at E1 with dbg_rvalid = 1 for exactly the cycle after E1.
REQ-014 FSM states SHALL be RUN, DRAIN, HALTED; reset state RUN.
REQ-015 RUN: on conflict (both valid) the requester selected by a 1-bit round-robin pointer SHALL be granted; pointer SHALL flip to the other requester after every accept; reset pointer selects core.
REQ-016 core_wr_ready SHALL be 1 only in RUN and only when dbg_valid = 0 or pointer selects core; dbg_ready SHALL be 1 in HALTED, or in RUN when core_wr_valid = 0 or pointer selects debug; neither ready SHALL depend on its own valid.
REQ-017 RUN -> DRAIN at an edge where dbg_halt_req = 1; no request SHALL be accepted in DRAIN.
REQ-018 DRAIN -> HALTED at an edge where iss_valid = 0 and dbg_halt_req = 1; DRAIN -> RUN at an edge where iss_valid = 0 and dbg_halt_req = 0.
REQ-019 HALTED -> RUN at an edge where dbg_halt_req = 0; only debug requests SHALL be accepted in HALTED.
REQ-020 dbg_halted SHALL equal (state == HALTED); core_stall SHALL equal (state != RUN).
REQ-021 A read accepted the cycle after a write to the same address SHALL return the newly written value (no forwarding required; write commits at E1 before read port is driven).
REQ-022 iss_valid SHALL clear at any edge where no request is accepted.

Reset
REQ-023 On reset assertion, immediately: state = RUN, pointer = core, iss_valid = 0, rf_reg_write = 0, rf_rd_addr = 0, rf_write_data = 0, dbg_rdata = 0, dbg_rvalid = 0, dbg_halted = 0, core_stall = 0.
REQ-024 A transaction in the issue register at reset SHALL be discarded; no rf_reg_write pulse SHALL follow deassertion.
REQ-025 After reset deassertion, the first request SHALL be acceptable in the first cycle.

Verification
REQ-026 Core write addr 2 data 0x5A, debug idle -> core_wr_ready = 1; rf_reg_write = 1, rf_rd_addr = 2, rf_write_data = 0x5A next cycle only.
REQ-027 Core and debug valid continuously for 4 cycles after reset -> accepts alternate core, debug, core, debug.
REQ-028 Core write addr 1 = 0x33, next cycle debug read addr 1 -> dbg_rvalid pulse with dbg_rdata = 0x33 two cycles after the read accept.
REQ-029 dbg_halt_req = 1 while core streams writes -> core_stall = 1 next cycle, dbg_halted = 1 after in-flight write commits, core_wr_ready = 0 throughout; debug write addr 3 = 0xFF accepted in HALTED; release -> RUN, core_stall = 0.
REQ-030 Reset asserted mid-cycle with write in issue register -> rf_reg_write = 0 immediately, no write after deassertion, all outputs at REQ-023 values.
REQ-031 dbg_halt_req pulsed for one cycle -> DRAIN then RUN without entering HALTED; dbg_halted stays 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one register-file port between core write-back and debug, with a halt handshake
//   clk, reset                                  clock, asynchronous active-high reset
//   core_wr_valid/addr/data, core_wr_ready      core write-back request
//   dbg_valid/we/addr/wdata, dbg_ready          debug read/write request
//   dbg_rdata, dbg_rvalid                       debug read data and one-cycle strobe
//   dbg_halt_req, dbg_halted, core_stall        halt handshake
//   rf_reg_write/rd_addr/write_data, rf_rd_data register file port
module regfile_port_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_wr_valid,
    input  logic [AW-1:0] core_wr_addr,
    input  logic [DW-1:0] core_wr_data,
    output logic          core_wr_ready,
    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    input  logic          dbg_halt_req,
    output logic          dbg_halted,
    output logic          core_stall,
    output logic          rf_reg_write,
    output logic [AW-1:0] rf_rd_addr,
    output logic [DW-1:0] rf_write_data,
    input  logic [DW-1:0] rf_rd_data
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t        state;
    logic          ptr;
    logic          iss_valid;
    logic          iss_we;
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_data;
    logic          acc_core;
    logic          acc_dbg;
    // ptr = 0 favours the core, 1 favours debug; each ready ignores its own valid
    assign core_wr_ready = state == RUN && (!dbg_valid || !ptr);
    assign dbg_ready     = state == HALTED || (state == RUN && (!core_wr_valid || ptr));
    assign acc_core      = core_wr_valid && core_wr_ready;
    assign acc_dbg       = dbg_valid && dbg_ready;
    assign dbg_halted    = state == HALTED;
    assign core_stall    = state != RUN;
    assign rf_rd_addr    = iss_addr;
    assign rf_write_data = iss_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            ptr          <= 1'b0;
            iss_valid    <= 1'b0;
            iss_we       <= 1'b0;
            iss_addr     <= '0;
            iss_data     <= '0;
            rf_reg_write <= 1'b0;
            dbg_rdata    <= '0;
            dbg_rvalid   <= 1'b0;
        end else begin
            iss_valid    <= acc_core || acc_dbg;
            rf_reg_write <= acc_core || (acc_dbg && dbg_we);
            if (acc_core) begin
                iss_we   <= 1'b1;
                iss_addr <= core_wr_addr;
                iss_data <= core_wr_data;
            end else if (acc_dbg) begin
                iss_we   <= dbg_we;
                iss_addr <= dbg_addr;
                iss_data <= dbg_wdata;
            end
            if (acc_core || acc_dbg)
                ptr <= ~ptr;
            // a debug read has had its address on the port for one cycle; take the data now
            dbg_rvalid <= iss_valid && !iss_we;
            if (iss_valid && !iss_we)
                dbg_rdata <= rf_rd_data;
            case (state)
                RUN:     if (dbg_halt_req) state <= DRAIN;
                DRAIN:   if (!iss_valid) state <= dbg_halt_req ? HALTED : RUN;
                HALTED:  if (!dbg_halt_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_regfile_port_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       core_wr_valid, dbg_valid, dbg_we, dbg_halt_req;
    logic [1:0] core_wr_addr, dbg_addr;
    logic [7:0] core_wr_data, dbg_wdata;
    logic       core_wr_ready, dbg_ready, dbg_rvalid, dbg_halted, core_stall, rf_reg_write;
    logic [7:0] dbg_rdata, rf_write_data, rf_rd_data;
    logic [1:0] rf_rd_addr;
    logic [7:0] rf_mem [4];
    int n_cmp = 0;
    int n_err = 0;

    regfile_port_arbiter #(.DW(8), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_ready(core_wr_ready),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted), .core_stall(core_stall),
        .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_write_data(rf_write_data),
        .rf_rd_data(rf_rd_data)
    );

    always #5 clk = ~clk;

    // external register file: write port and combinational read share rf_rd_addr
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
        end else if (rf_reg_write) begin
            rf_mem[rf_rd_addr] <= rf_write_data;
        end
    end
    assign rf_rd_data = rf_mem[rf_rd_addr];

    task automatic idle();
        core_wr_valid = 0; core_wr_addr = 0; core_wr_data = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_halt_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (rf_reg_write !== 1'b0) begin n_err++; $display("FAIL reset_rf_reg_write got %0b want 0", rf_reg_write); end
        n_cmp++; if (rf_rd_addr !== 2'd0) begin n_err++; $display("FAIL reset_rf_rd_addr got %0h want 0", rf_rd_addr); end
        n_cmp++; if (rf_write_data !== 8'h00) begin n_err++; $display("FAIL reset_rf_write_data got %0h want 0", rf_write_data); end
        n_cmp++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h00) begin n_err++; $display("FAIL reset_dbg_read got %0b/%0h want 0/0", dbg_rvalid, dbg_rdata); end
        n_cmp++; if (dbg_halted !== 1'b0 || core_stall !== 1'b0) begin n_err++; $display("FAIL reset_halt got %0b/%0b want 0/0", dbg_halted, core_stall); end
        n_cmp++; if (core_wr_ready !== 1'b1 || dbg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b/%0b want 1/1", core_wr_ready, dbg_ready); end
    endtask

    task automatic test_core_write();
        do_reset();
        core_wr_valid = 1; core_wr_addr = 2; core_wr_data = 8'h5A;
        #1;
        n_cmp++; if (core_wr_ready !== 1'b1) begin n_err++; $display("FAIL cw_ready got %0b want 1", core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rf_reg_write !== 1'b1 || rf_rd_addr !== 2'd2 || rf_write_data !== 8'h5A)
            begin n_err++; $display("FAIL cw_port got %0b/%0h/%0h want 1/2/5a", rf_reg_write, rf_rd_addr, rf_write_data); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        n_cmp++; if (rf_reg_write !== 1'b0 || rf_rd_addr !== 2'd2 || rf_write_data !== 8'h5A)
            begin n_err++; $display("FAIL cw_hold got %0b/%0h/%0h want 0/2/5a", rf_reg_write, rf_rd_addr, rf_write_data); end
        n_cmp++; if (rf_mem[2] !== 8'h5A) begin n_err++; $display("FAIL cw_commit got %0h want 5a", rf_mem[2]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_wr_valid = 1; core_wr_addr = 2'(i); core_wr_data = 8'(i + 16);
            dbg_valid = 1; dbg_we = 0; dbg_addr = 2'(i);
            #1;
            n_cmp++; if (core_wr_ready !== (i % 2 == 0) || dbg_ready !== (i % 2 == 1))
                begin n_err++; $display("FAIL rr_grant%0d got %0b/%0b want %0b/%0b", i, core_wr_ready, dbg_ready, i % 2 == 0, i % 2 == 1); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_read_after_write();
        do_reset();
        core_wr_valid = 1; core_wr_addr = 1; core_wr_data = 8'h33;
        @(negedge clk);
        core_wr_valid = 0; dbg_valid = 1; dbg_we = 0; dbg_addr = 1;
        #1;
        n_cmp++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL raw_ready got %0b want 1", dbg_ready); end
        @(posedge clk); #1;
        n_cmp++; if (dbg_rvalid !== 1'b0 || rf_rd_addr !== 2'd1) begin n_err++; $display("FAIL raw_e0 got %0b/%0h want 0/1", dbg_rvalid, rf_rd_addr); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'h33) begin n_err++; $display("FAIL raw_data got %0b/%0h want 1/33", dbg_rvalid, dbg_rdata); end
        @(posedge clk); #1;
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL raw_strobe got %0b want 0", dbg_rvalid); end
    endtask

    task automatic test_halt();
        do_reset();
        core_wr_valid = 1; core_wr_addr = 0; core_wr_data = 8'h01;
        @(negedge clk);
        core_wr_addr = 1; core_wr_data = 8'h02; dbg_halt_req = 1;
        #1;
        n_cmp++; if (core_wr_ready !== 1'b1) begin n_err++; $display("FAIL halt_last_ready got %0b want 1", core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (core_stall !== 1'b1 || dbg_halted !== 1'b0 || rf_reg_write !== 1'b1)
            begin n_err++; $display("FAIL halt_drain got %0b/%0b/%0b want 1/0/1", core_stall, dbg_halted, rf_reg_write); end
        @(negedge clk); core_wr_data = 8'h03; #1;
        n_cmp++; if (core_wr_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready1 got %0b want 0", core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (dbg_halted !== 1'b0 || rf_reg_write !== 1'b0 || rf_mem[1] !== 8'h02)
            begin n_err++; $display("FAIL halt_commit got %0b/%0b/%0h want 0/0/02", dbg_halted, rf_reg_write, rf_mem[1]); end
        @(negedge clk); #1;
        n_cmp++; if (core_wr_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready2 got %0b want 0", core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (dbg_halted !== 1'b1 || core_stall !== 1'b1) begin n_err++; $display("FAIL halt_halted got %0b/%0b want 1/1", dbg_halted, core_stall); end
        @(negedge clk); dbg_valid = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 8'hFF; #1;
        n_cmp++; if (dbg_ready !== 1'b1 || core_wr_ready !== 1'b0) begin n_err++; $display("FAIL halt_dbg_ready got %0b/%0b want 1/0", dbg_ready, core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rf_reg_write !== 1'b1 || rf_rd_addr !== 2'd3 || rf_write_data !== 8'hFF)
            begin n_err++; $display("FAIL halt_dbg_wr got %0b/%0h/%0h want 1/3/ff", rf_reg_write, rf_rd_addr, rf_write_data); end
        @(negedge clk); dbg_valid = 0; dbg_halt_req = 0;
        @(posedge clk); #1;
        n_cmp++; if (core_stall !== 1'b0 || dbg_halted !== 1'b0 || rf_mem[3] !== 8'hFF || rf_mem[1] !== 8'h02)
            begin n_err++; $display("FAIL halt_release got %0b/%0b/%0h/%0h want 0/0/ff/02", core_stall, dbg_halted, rf_mem[3], rf_mem[1]); end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        core_wr_valid = 1; core_wr_addr = 0; core_wr_data = 8'hC3;
        @(posedge clk); #1;
        n_cmp++; if (rf_reg_write !== 1'b1) begin n_err++; $display("FAIL rm_pre got %0b want 1", rf_reg_write); end
        #2 reset = 1;
        #1;
        n_cmp++; if (rf_reg_write !== 1'b0 || rf_rd_addr !== 2'd0 || rf_write_data !== 8'h00 || dbg_rvalid !== 1'b0 || core_stall !== 1'b0 || dbg_halted !== 1'b0)
            begin n_err++; $display("FAIL rm_async got %0b/%0h/%0h/%0b/%0b/%0b want 0/0/0/0/0/0", rf_reg_write, rf_rd_addr, rf_write_data, dbg_rvalid, core_stall, dbg_halted); end
        @(negedge clk);
        reset = 0;
        core_wr_addr = 1; core_wr_data = 8'h77;
        #1;
        n_cmp++; if (core_wr_ready !== 1'b1) begin n_err++; $display("FAIL rm_first_ready got %0b want 1", core_wr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rf_mem[0] !== 8'h00 || rf_rd_addr !== 2'd1 || rf_write_data !== 8'h77)
            begin n_err++; $display("FAIL rm_discard got %0h/%0h/%0h want 00/1/77", rf_mem[0], rf_rd_addr, rf_write_data); end
        @(negedge clk); idle();
    endtask

    task automatic test_halt_pulse();
        do_reset();
        dbg_halt_req = 1;
        @(posedge clk); #1;
        n_cmp++; if (core_stall !== 1'b1 || dbg_halted !== 1'b0) begin n_err++; $display("FAIL pulse_drain got %0b/%0b want 1/0", core_stall, dbg_halted); end
        @(negedge clk); dbg_halt_req = 0;
        @(posedge clk); #1;
        n_cmp++; if (core_stall !== 1'b0 || dbg_halted !== 1'b0) begin n_err++; $display("FAIL pulse_run got %0b/%0b want 0/0", core_stall, dbg_halted); end
    endtask

    task automatic test_random();
        int mode;
        bit ptr_m, iv, iw, ac, ad, ecr, edr, rv;
        logic [1:0] ia;
        logic [7:0] id, ird, rd;
        logic [7:0] mm [4];
        do_reset();
        mode = 0; ptr_m = 0; iv = 0; iw = 0; ia = 0; id = 0; ird = 0; rv = 0; rd = 0;
        for (int i = 0; i < 4; i++) mm[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            core_wr_valid = 1'($urandom_range(0, 1)); core_wr_addr = 2'($urandom); core_wr_data = 8'($urandom);
            dbg_valid = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 2'($urandom); dbg_wdata = 8'($urandom);
            if ($urandom_range(0, 9) == 0) dbg_halt_req = !dbg_halt_req;
            #1;
            ecr = mode == 0 && (!dbg_valid || !ptr_m);
            edr = mode == 2 || (mode == 0 && (!core_wr_valid || ptr_m));
            n_cmp++; if (core_wr_ready !== ecr || dbg_ready !== edr)
                begin n_err++; $display("FAIL rnd_ready c%0d got %0b/%0b want %0b/%0b", c, core_wr_ready, dbg_ready, ecr, edr); end
            ac = core_wr_valid && ecr;
            ad = dbg_valid && edr && !ac;
            @(posedge clk); #1;
            rv = iv && !iw;
            if (rv) rd = ird;
            if (mode == 0 && dbg_halt_req) mode = 1;
            else if (mode == 1 && !iv) mode = dbg_halt_req ? 2 : 0;
            else if (mode == 2 && !dbg_halt_req) mode = 0;
            iv = ac || ad;
            if (ac) begin
                iw = 1; ia = core_wr_addr; id = core_wr_data; mm[ia] = id;
            end else if (ad) begin
                iw = dbg_we; ia = dbg_addr; id = dbg_wdata;
                if (dbg_we) mm[ia] = id; else ird = mm[ia];
            end
            if (iv) ptr_m = !ptr_m;
            n_cmp++; if (rf_reg_write !== (iv && iw) || rf_rd_addr !== ia || (iv && iw && rf_write_data !== id))
                begin n_err++; $display("FAIL rnd_port c%0d got %0b/%0h/%0h want %0b/%0h/%0h", c, rf_reg_write, rf_rd_addr, rf_write_data, iv && iw, ia, id); end
            n_cmp++; if (dbg_rvalid !== rv || (rv && dbg_rdata !== rd))
                begin n_err++; $display("FAIL rnd_read c%0d got %0b/%0h want %0b/%0h", c, dbg_rvalid, dbg_rdata, rv, rd); end
            n_cmp++; if (core_stall !== (mode != 0) || dbg_halted !== (mode == 2))
                begin n_err++; $display("FAIL rnd_state c%0d got %0b/%0b want %0b/%0b", c, core_stall, dbg_halted, mode != 0, mode == 2); end
        end
        @(negedge clk); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_core_write();
        test_round_robin();
        test_read_after_write();
        test_halt();
        test_reset_mid();
        test_halt_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
